// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants and types for the I2S receiver.
//   MODE_I2S / MODE_LJ : slot alignment encodings for the MODE parameter
//   OUT_W              : width of the formatted output samples
//   frame_st_t         : framing state (hunting for alignment, in left slot, in right slot)
package i2s_pkg;
    localparam int OUT_W    = 32;
    localparam int MODE_I2S = 0;
    localparam int MODE_LJ  = 1;
    typedef enum logic [1:0] {ST_HUNT, ST_LEFT, ST_RIGHT} frame_st_t;
endpackage

// File: rtl/i2s_slot_shifter.sv
// i2s_slot_shifter: collects one slot MSB-first and presents it formatted to OUT_W bits.
//   sck   : bit clock
//   rst_n : synchronous active-low reset
//   start : slot-start strobe; the sd bit on this edge becomes the new slot MSB
//   sd    : serial data
//   slot  : current (closing) slot, unreceived LSBs zero, MSB-aligned or sign-extended
//   full  : DATA_W bits have been received for the current slot
module i2s_slot_shifter
    import i2s_pkg::*;
#(
    parameter int DATA_W   = 24,
    parameter int SIGN_EXT = 0
) (
    input  logic             sck,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sd,
    output logic [OUT_W-1:0] slot,
    output logic             full
);
    localparam int CW  = $clog2(DATA_W + 1);
    localparam int PAD = OUT_W - DATA_W;

    logic [DATA_W-1:0]       word;
    logic [CW-1:0]           cnt;
    logic [OUT_W-1:0]        msb_al;
    logic signed [OUT_W-1:0] ext;

    // Bits land at their final position, so a short slot is already zero-filled.
    always_ff @(posedge sck) begin
        if (!rst_n) begin
            word <= '0;
            cnt  <= '0;
        end else if (start) begin
            word <= DATA_W'(sd) << (DATA_W - 1);
            cnt  <= CW'(1);
        end else if (!full) begin
            word <= word | (DATA_W'(sd) << (CW'(DATA_W - 1) - cnt));
            cnt  <= cnt + 1'b1;
        end
    end

    assign full   = cnt == CW'(DATA_W);
    assign msb_al = OUT_W'(word) << PAD;
    // Separate signed net keeps the shift arithmetic regardless of the mux context.
    assign ext    = $signed(msb_al) >>> PAD;
    assign slot   = SIGN_EXT != 0 ? $unsigned(ext) : msb_al;
endmodule

// File: rtl/i2s_rx_param.sv
// i2s_rx_param: I2S / left-justified receiver with frame lock and valid/ready output.
//   sck        : bit clock, all logic on posedge
//   rst_n      : synchronous active-low reset
//   ws         : word select (0 left, 1 right)
//   sd         : serial data, MSB first
//   data_left  : left sample of the last committed frame
//   data_right : right sample of the last committed frame
//   out_valid  : committed frame pending
//   out_ready  : consumer accepts the pending frame
//   overrun    : pulse when a pending frame is overwritten
//   short_err  : pulse when a slot closes short, or a right slot closes without its left
//   locked     : frame alignment acquired
module i2s_rx_param
    import i2s_pkg::*;
#(
    parameter int DATA_W   = 24,
    parameter int MODE     = 0,
    parameter int SIGN_EXT = 0
) (
    input  logic             sck,
    input  logic             rst_n,
    input  logic             ws,
    input  logic             sd,
    output logic [OUT_W-1:0] data_left,
    output logic [OUT_W-1:0] data_right,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             short_err,
    output logic             locked
);
    logic             wsd, wsdd, start, side, full, commit, hold, err;
    logic [OUT_W-1:0] slot, left_hold;
    frame_st_t        st, st_n;

    // In I2S mode the MSB trails the ws transition by one bit clock.
    assign start  = MODE == MODE_LJ ? ws != wsd : wsd != wsdd;
    assign side   = MODE == MODE_LJ ? ws : wsd;
    assign locked = st != ST_HUNT;

    i2s_slot_shifter #(.DATA_W(DATA_W), .SIGN_EXT(SIGN_EXT)) u_shift (
        .sck   (sck),
        .rst_n (rst_n),
        .start (start),
        .sd    (sd),
        .slot  (slot),
        .full  (full)
    );

    always_ff @(posedge sck) begin
        if (!rst_n) st <= ST_HUNT;
        else        st <= st_n;
    end

    // A slot start of side s closes the slot of side !s.
    always_comb begin
        st_n   = st;
        commit = 1'b0;
        hold   = 1'b0;
        err    = 1'b0;
        case (st)
            ST_HUNT:  st_n = start && !side ? ST_LEFT : ST_HUNT;
            ST_LEFT:  if (start) begin
                hold = side;
                err  = side ? !full : 1'b1;
                st_n = side ? ST_RIGHT : ST_LEFT;
            end
            ST_RIGHT: if (start) begin
                commit = !side;
                hold   = side;
                err    = !full;
                st_n   = side ? ST_RIGHT : ST_LEFT;
            end
            default:  st_n = ST_HUNT;
        endcase
    end

    always_ff @(posedge sck) begin
        if (!rst_n) begin
            wsd        <= 1'b0;
            wsdd       <= 1'b0;
            left_hold  <= '0;
            data_left  <= '0;
            data_right <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
            short_err  <= 1'b0;
        end else begin
            wsd       <= ws;
            wsdd      <= wsd;
            short_err <= err;
            overrun   <= commit && out_valid && !out_ready;
            if (hold) left_hold <= slot;
            if (commit) begin
                data_left  <= left_hold;
                data_right <= slot;
                out_valid  <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_i2s_rx_param.sv
// tb_i2s_rx_param: directed self-checking bench for i2s_rx_param.
//   u0: MODE=0 (I2S), DATA_W=24, SIGN_EXT=0; u1: MODE=1 (LJ), DATA_W=16, SIGN_EXT=1.
module tb_i2s_rx_param;
    logic        sck = 1'b0, rst_n = 1'b0, ws = 1'b0, sd = 1'b0, out_ready = 1'b0;
    logic [31:0] dl0, dr0, dl1, dr1;
    logic        vld0, ovr0, se0, lk0, vld1, ovr1, se1, lk1;
    logic        mode = 1'b0, lastbit = 1'b0;
    int          checks = 0, errors = 0;

    i2s_rx_param #(.DATA_W(24), .MODE(0), .SIGN_EXT(0)) u0 (
        .sck(sck), .rst_n(rst_n), .ws(ws), .sd(sd), .data_left(dl0), .data_right(dr0),
        .out_valid(vld0), .out_ready(out_ready), .overrun(ovr0), .short_err(se0), .locked(lk0)
    );
    i2s_rx_param #(.DATA_W(16), .MODE(1), .SIGN_EXT(1)) u1 (
        .sck(sck), .rst_n(rst_n), .ws(ws), .sd(sd), .data_left(dl1), .data_right(dr1),
        .out_valid(vld1), .out_ready(out_ready), .overrun(ovr1), .short_err(se1), .locked(lk1)
    );

    always #5 sck = ~sck;

    // Sends bit positions lo..hi-1 of a slot whose content is v (MSB at bit 31).
    // In I2S mode sd lags ws by one bit, so the previous data bit goes out each clock.
    task automatic slot(input logic w, input logic [31:0] v, input int lo, input int hi);
        for (int k = lo; k < hi; k++) begin
            @(negedge sck);
            ws      = w;
            sd      = mode ? v[31-k] : lastbit;
            lastbit = v[31-k];
            @(posedge sck);
            #1;
        end
    endtask

    task automatic do_reset(input logic w);
        @(negedge sck);
        rst_n   = 1'b0;
        ws      = w;
        sd      = 1'b0;
        lastbit = 1'b0;
        @(posedge sck);
        @(negedge sck);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge sck);
        #1;
        checks++; if (dl0 !== 32'h0 || dr0 !== 32'h0) begin errors++; $display("FAIL reset_data0 got %h/%h exp 0/0", dl0, dr0); end
        checks++; if ({vld0, ovr0, se0, lk0} !== 4'b0) begin errors++; $display("FAIL reset_flags0 got %b exp 0000", {vld0, ovr0, se0, lk0}); end
        checks++; if (dl1 !== 32'h0 || dr1 !== 32'h0) begin errors++; $display("FAIL reset_data1 got %h/%h exp 0/0", dl1, dr1); end
        checks++; if ({vld1, ovr1, se1, lk1} !== 4'b0) begin errors++; $display("FAIL reset_flags1 got %b exp 0000", {vld1, ovr1, se1, lk1}); end
    endtask

    task automatic test_i2s_basic;
        mode = 1'b0; out_ready = 1'b1; do_reset(1'b0);
        slot(1'b1, 32'h0, 0, 32);
        slot(1'b0, 32'hABCDEF00, 0, 1);
        checks++; if (lk0 !== 1'b0) begin errors++; $display("FAIL i2s_prelock got %b exp 0", lk0); end
        slot(1'b0, 32'hABCDEF00, 1, 2);
        checks++; if (lk0 !== 1'b1 || vld0 !== 1'b0) begin errors++; $display("FAIL i2s_lock got lk=%b vld=%b exp 1/0", lk0, vld0); end
        slot(1'b0, 32'hABCDEF00, 2, 32);
        slot(1'b1, 32'h12345600, 0, 32);
        slot(1'b0, 32'h80000100, 0, 1);
        checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL i2s_latency_early got vld=%b exp 0", vld0); end
        slot(1'b0, 32'h80000100, 1, 2);
        checks++; if (vld0 !== 1'b1 || se0 !== 1'b0) begin errors++; $display("FAIL i2s_commit got vld=%b se=%b exp 1/0", vld0, se0); end
        checks++; if (dl0 !== 32'hABCDEF00) begin errors++; $display("FAIL i2s_left got %h exp abcdef00", dl0); end
        checks++; if (dr0 !== 32'h12345600) begin errors++; $display("FAIL i2s_right got %h exp 12345600", dr0); end
        slot(1'b0, 32'h80000100, 2, 3);
        checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL i2s_valid_drop got %b exp 0", vld0); end
        slot(1'b0, 32'h80000100, 3, 32);
        slot(1'b1, 32'h7FFFFE00, 0, 32);
        slot(1'b0, 32'h0, 0, 2);
        checks++; if (vld0 !== 1'b1 || dl0 !== 32'h80000100 || dr0 !== 32'h7FFFFE00) begin errors++; $display("FAIL i2s_frame2 got %b %h %h exp 1 80000100 7ffffe00", vld0, dl0, dr0); end
    endtask

    task automatic test_lj_sign_ext;
        mode = 1'b1; out_ready = 1'b1; do_reset(1'b0);
        slot(1'b1, 32'h0, 0, 16);
        slot(1'b0, 32'h80010000, 0, 1);
        checks++; if (lk1 !== 1'b1) begin errors++; $display("FAIL lj_lock got %b exp 1", lk1); end
        slot(1'b0, 32'h80010000, 1, 16);
        slot(1'b1, 32'h7FFF0000, 0, 1);
        checks++; if (se1 !== 1'b0) begin errors++; $display("FAIL lj_no_short got %b exp 0", se1); end
        slot(1'b1, 32'h7FFF0000, 1, 16);
        slot(1'b0, 32'h00010000, 0, 1);
        checks++; if (vld1 !== 1'b1 || dl1 !== 32'hFFFF8001 || dr1 !== 32'h00007FFF) begin errors++; $display("FAIL lj_frame1 got %b %h %h exp 1 ffff8001 00007fff", vld1, dl1, dr1); end
        slot(1'b0, 32'h00010000, 1, 16);
        slot(1'b1, 32'hFFFF0000, 0, 16);
        slot(1'b0, 32'h0, 0, 1);
        checks++; if (dl1 !== 32'h00000001 || dr1 !== 32'hFFFFFFFF) begin errors++; $display("FAIL lj_frame2 got %h %h exp 00000001 ffffffff", dl1, dr1); end
    endtask

    task automatic test_overrun;
        mode = 1'b0; out_ready = 1'b0; do_reset(1'b0);
        slot(1'b1, 32'h0, 0, 32);
        slot(1'b0, 32'h11111100, 0, 32);
        slot(1'b1, 32'h22222200, 0, 32);
        slot(1'b0, 32'h33333300, 0, 2);
        checks++; if (vld0 !== 1'b1 || ovr0 !== 1'b0) begin errors++; $display("FAIL ovr_first got vld=%b ovr=%b exp 1/0", vld0, ovr0); end
        slot(1'b0, 32'h33333300, 2, 32);
        slot(1'b1, 32'h44444400, 0, 32);
        slot(1'b0, 32'h0, 0, 2);
        checks++; if (vld0 !== 1'b1 || ovr0 !== 1'b1) begin errors++; $display("FAIL ovr_pulse got vld=%b ovr=%b exp 1/1", vld0, ovr0); end
        checks++; if (dl0 !== 32'h33333300 || dr0 !== 32'h44444400) begin errors++; $display("FAIL ovr_data got %h %h exp 33333300 44444400", dl0, dr0); end
        slot(1'b0, 32'h0, 2, 3);
        checks++; if (vld0 !== 1'b1 || ovr0 !== 1'b0) begin errors++; $display("FAIL ovr_once got vld=%b ovr=%b exp 1/0", vld0, ovr0); end
        out_ready = 1'b1;
        slot(1'b0, 32'h0, 3, 4);
        checks++; if (vld0 !== 1'b0 || dl0 !== 32'h33333300) begin errors++; $display("FAIL ovr_accept got vld=%b dl=%h exp 0 33333300", vld0, dl0); end
    endtask

    task automatic test_short_slots;
        mode = 1'b0; out_ready = 1'b1; do_reset(1'b0);
        slot(1'b1, 32'h0, 0, 16);
        slot(1'b0, 32'h12340000, 0, 2);
        checks++; if (lk0 !== 1'b1 || se0 !== 1'b0) begin errors++; $display("FAIL short_lock got lk=%b se=%b exp 1/0", lk0, se0); end
        slot(1'b0, 32'h12340000, 2, 16);
        slot(1'b1, 32'h56780000, 0, 2);
        checks++; if (se0 !== 1'b1) begin errors++; $display("FAIL short_left got %b exp 1", se0); end
        slot(1'b1, 32'h56780000, 2, 3);
        checks++; if (se0 !== 1'b0) begin errors++; $display("FAIL short_pulse_width got %b exp 0", se0); end
        slot(1'b1, 32'h56780000, 3, 16);
        slot(1'b0, 32'h12340000, 0, 2);
        checks++; if (se0 !== 1'b1 || vld0 !== 1'b1) begin errors++; $display("FAIL short_right got se=%b vld=%b exp 1/1", se0, vld0); end
        checks++; if (dl0 !== 32'h12340000 || dr0 !== 32'h56780000) begin errors++; $display("FAIL short_data got %h %h exp 12340000 56780000", dl0, dr0); end
    endtask

    task automatic test_reset_mid_right;
        mode = 1'b0; out_ready = 1'b1; do_reset(1'b1);
        slot(1'b1, 32'hFFFFFFFF, 10, 32);
        checks++; if (lk0 !== 1'b0 || vld0 !== 1'b0) begin errors++; $display("FAIL midr_unlocked got lk=%b vld=%b exp 0/0", lk0, vld0); end
        slot(1'b0, 32'hC0FFEE00, 0, 2);
        checks++; if (lk0 !== 1'b1 || vld0 !== 1'b0 || se0 !== 1'b0) begin errors++; $display("FAIL midr_lock got lk=%b vld=%b se=%b exp 1/0/0", lk0, vld0, se0); end
        slot(1'b0, 32'hC0FFEE00, 2, 32);
        slot(1'b1, 32'h0BEEF000, 0, 32);
        slot(1'b0, 32'h0, 0, 2);
        checks++; if (vld0 !== 1'b1 || dl0 !== 32'hC0FFEE00 || dr0 !== 32'h0BEEF000) begin errors++; $display("FAIL midr_frame got %b %h %h exp 1 c0ffee00 0beef000", vld0, dl0, dr0); end
    endtask

    task automatic test_reset_mid_left;
        mode = 1'b0; out_ready = 1'b0; do_reset(1'b0);
        slot(1'b1, 32'h0, 0, 32);
        slot(1'b0, 32'h0F0F0F00, 0, 32);
        slot(1'b1, 32'hF0F0F000, 0, 32);
        slot(1'b0, 32'h0F0F0F00, 0, 2);
        checks++; if (vld0 !== 1'b1 || dl0 !== 32'h0F0F0F00) begin errors++; $display("FAIL midl_pending got vld=%b dl=%h exp 1 0f0f0f00", vld0, dl0); end
        slot(1'b0, 32'h0F0F0F00, 2, 10);
        rst_n = 1'b0;
        slot(1'b0, 32'h0F0F0F00, 10, 11);
        rst_n = 1'b1;
        checks++; if (dl0 !== 32'h0 || dr0 !== 32'h0 || {vld0, ovr0, se0, lk0} !== 4'b0) begin errors++; $display("FAIL midl_reset got %h %h %b exp 0 0 0000", dl0, dr0, {vld0, ovr0, se0, lk0}); end
        slot(1'b0, 32'h0F0F0F00, 11, 32);
        slot(1'b1, 32'hF0F0F000, 0, 32);
        checks++; if (lk0 !== 1'b0 || vld0 !== 1'b0) begin errors++; $display("FAIL midl_unlocked got lk=%b vld=%b exp 0/0", lk0, vld0); end
        slot(1'b0, 32'h55AA5500, 0, 2);
        checks++; if (lk0 !== 1'b1 || vld0 !== 1'b0 || se0 !== 1'b0) begin errors++; $display("FAIL midl_relock got lk=%b vld=%b se=%b exp 1/0/0", lk0, vld0, se0); end
        slot(1'b0, 32'h55AA5500, 2, 32);
        slot(1'b1, 32'hAA55AA00, 0, 32);
        slot(1'b0, 32'h0, 0, 2);
        checks++; if (vld0 !== 1'b1 || dl0 !== 32'h55AA5500 || dr0 !== 32'hAA55AA00) begin errors++; $display("FAIL midl_frame got %b %h %h exp 1 55aa5500 aa55aa00", vld0, dl0, dr0); end
    endtask

    initial begin
        test_reset;
        test_i2s_basic;
        test_lj_sign_ext;
        test_overrun;
        test_short_slots;
        test_reset_mid_right;
        test_reset_mid_left;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2s_rx_param.md
I2S_RX_PARAM -- requirements
Module: i2s_rx_param

Interface
REQ-001 SHALL have parameter DATA_W, default 24, captured bits per slot (legal 8..32).
REQ-002 SHALL have parameter MODE, default 0, slot alignment (0 = Philips I2S with 1-bit delay, 1 = left-justified).
REQ-003 SHALL have parameter SIGN_EXT, default 0 (0 = MSB-aligned in 32 bits with zero LSB pad, 1 = right-aligned and sign-extended to 32 bits).
REQ-004 SHALL have port sck, input, 1, I2S bit clock; sole clock, all logic on posedge.
REQ-005 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port ws, input, 1, word select (0 = left slot, 1 = right slot).
REQ-007 SHALL have port sd, input, 1, serial data, MSB first.
REQ-008 SHALL have port data_left, output, 32, left sample of last committed frame.
REQ-009 SHALL have port data_right, output, 32, right sample of last committed frame.
REQ-010 SHALL have port out_valid, output, 1, committed frame pending.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts frame when high with out_valid.
REQ-012 SHALL have port overrun, output, 1, one-cycle pulse when a pending frame is overwritten.
REQ-013 SHALL have port short_err, output, 1, one-cycle pulse when a slot closes with fewer than DATA_W bits.
REQ-014 SHALL have port locked, output, 1, high once frame alignment is acquired.

Function
REQ-015 SHALL register ws every posedge (wsd, wsdd); edge = ws != wsd.
REQ-016 SHALL define slot start as edge when MODE=1, and wsd != wsdd when MODE=0; the sd bit sampled on the slot-start posedge is the MSB.
REQ-017 SHALL shift sd into a DATA_W shifter each posedge from slot start onward; bit counter saturates at DATA_W; later bits ignored.
REQ-018 SHALL, on slot start, close the previous slot: zero-fill unreceived LSBs; if count < DATA_W, pulse short_err in the next cycle.
REQ-019 SHALL format closed slot per SIGN_EXT: 0 -> {word, (32-DATA_W) zeros}; 1 -> word sign-extended from bit DATA_W-1.
REQ-020 SHALL hold a closed left slot internally; on closing a right slot, commit the held left and the right to data_left/data_right and set out_valid in the next cycle.
REQ-021 SHALL clear out_valid on a cycle with out_valid && out_ready and no new commit.
REQ-022 SHALL, on commit with out_valid && !out_ready, overwrite both outputs, keep out_valid high, and pulse overrun.
REQ-023 SHALL, on commit coinciding with out_valid && out_ready, load new data, keep out_valid high, no overrun.
REQ-024 SHALL stay unlocked after reset until the first left slot start (ws falling edge); slots closed while unlocked are discarded, no commit, no short_err.
REQ-025 SHALL set locked on that first left slot start; a right slot closing without a preceding left slot (lost left) is discarded and short_err pulses.
REQ-026 SHALL keep latency fixed: data and out_valid updated exactly one posedge after the closing slot start.

Reset
REQ-027 SHALL, while rst_n=0 on a posedge: data_left=0, data_right=0, out_valid=0, overrun=0, short_err=0, locked=0, shifter, counter, left hold, wsd, wsdd cleared (wsd, wsdd = 0).
REQ-028 SHALL abandon any partial slot on reset mid-frame; no commit from pre-reset bits.

Structure
REQ-029 SHALL place MODE encodings (MODE_I2S=0, MODE_LJ=1) and OUT_W=32 in shared package i2s_pkg.
REQ-030 SHALL implement shifter, bit counter and formatting in sub-module i2s_slot_shifter (parameters DATA_W, SIGN_EXT); framing, lock and handshake in the top.

Verification
REQ-031 SHALL cover MODE=0, DATA_W=24, 32-bit slots, L=0xABCDEF, R=0x123456, out_ready=1 -> data_left=0xABCDEF00, data_right=0x12345600, out_valid one cycle per frame.
REQ-032 SHALL cover MODE=1, DATA_W=16, SIGN_EXT=1, L=0x8001, R=0x7FFF -> data_left=0xFFFF8001, data_right=0x00007FFF.
REQ-033 SHALL cover out_ready=0 across two frames -> overrun pulses once, outputs hold second frame, out_valid stays 1 until out_ready.
REQ-034 SHALL cover DATA_W=24 with 16-bit slots, L=0x1234 -> short_err pulses per slot, data_left=0x12340000.
REQ-035 SHALL cover reset released mid right slot -> locked=0 and no commit until first ws falling edge; first full frame commits correctly.
REQ-036 SHALL cover rst_n low for one cycle mid left slot -> all outputs 0, partial slot discarded, relock on next left slot.
